// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types, constants and helpers for the shift_sched
//                block: FSM state encoding, datapath widths and a 16-bit
//                bit-reverse function used by the rotate path.
//  Optional    : SHIFT_SCHED_ROT_EN (users of bitreverse16)
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] bitreverse16(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sched_if
//  Description : Request/response bundle between ALU-side requesters and the
//                shared-shifter scheduler.
//  Signals     : req_valid/req_ready [NREQ]   per-requester handshake
//                req_data [16*NREQ]           operand, requester k at [16k+:16]
//                req_amt  [4*NREQ]            shift amount, requester k at [4k+:4]
//                req_rot  [NREQ]              rotate select (SHIFT_SCHED_ROT_EN)
//                rsp_valid/rsp_ready          result handshake
//                rsp_data [16], rsp_id [IDW]  result and issuing requester
//  Modports    : master (requester/consumer side), slave (scheduler side)
//  Optional    : SHIFT_SCHED_ROT_EN adds req_rot
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
);
    import shift_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W*NREQ-1:0] req_data;
    logic [AMT_W*NREQ-1:0]  req_amt;
`ifdef SHIFT_SCHED_ROT_EN
    logic [NREQ-1:0]        req_rot;
`endif
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_W-1:0]      rsp_data;
    logic [IDW-1:0]         rsp_id;

    modport master (
`ifdef SHIFT_SCHED_ROT_EN
        output req_rot,
`endif
        output req_valid, req_data, req_amt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
`ifdef SHIFT_SCHED_ROT_EN
        input  req_rot,
`endif
        input  req_valid, req_data, req_amt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface
`default_nettype wire

// File: rtl/shift_sched_barrel.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sched_barrel
//  Description : 16-bit logarithmic left barrel shifter, zero fill.
//                Purely combinational; stage sN shifts by 2**N.
//  Ports       : i_data [16]   operand
//                i_s0..i_s3    stage selects (amount bits 0..3)
//                o_data [16]   shifted result
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sched_barrel (
    input  wire logic [15:0] i_data,
    input  wire logic        i_s0,
    input  wire logic        i_s1,
    input  wire logic        i_s2,
    input  wire logic        i_s3,
    output logic      [15:0] o_data
);

    logic [15:0] w_st1;
    logic [15:0] w_st2;
    logic [15:0] w_st3;

    assign w_st1  = i_s0 ? {i_data[14:0], 1'b0}  : i_data;
    assign w_st2  = i_s1 ? {w_st1[13:0], 2'b00}  : w_st1;
    assign w_st3  = i_s2 ? {w_st2[11:0], 4'h0}   : w_st2;
    assign o_data = i_s3 ? {w_st3[7:0],  8'h00}  : w_st3;

endmodule
`default_nettype wire

// File: rtl/shift_sched.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sched
//  Description : Shared-shifter scheduler. Round-robin arbitration among NREQ
//                requesters; each granted operation runs through one shared
//                16-bit left barrel shifter in one pass (shift) or two passes
//                (rotate), then the result is returned with the requester id.
//  Ports       : clk     single clock, rising edge
//                rst_n   synchronous active-low reset
//                bus     shift_sched_if.slave (request/response bundle)
//  Optional    : SHIFT_SCHED_ROT_EN builds req_rot, PASS2 and bit-reverse
//                logic; without it every operation is a plain left shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sched
    import shift_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    shift_sched_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [DATA_W-1:0] r_opnd;
    logic [DATA_W-1:0] r_acc;
    logic [AMT_W-1:0]  r_amt;
`ifdef SHIFT_SCHED_ROT_EN
    logic              r_rot;
`endif

    logic [IDW-1:0]    w_grant;
    logic [IDW-1:0]    w_cand;
    int                w_idx;
    logic              w_found;
    logic              w_accept;
    logic [DATA_W-1:0] w_sh_in;
    logic [DATA_W-1:0] w_sh_out;
    logic [AMT_W-1:0]  w_sh_amt;

    // Round-robin search starting one past the last grant.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx  = (int'(r_ptr) + i) % NREQ;
            w_cand = IDW'(w_idx);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found;

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && w_accept) begin
            bus.req_ready[w_grant] = 1'b1;
        end
    end

    // Second pass shifts the bit-reversed operand right-equivalent by
    // 16-amt, recovering the bits the first pass dropped off the top.
`ifdef SHIFT_SCHED_ROT_EN
    always_comb begin
        w_sh_in  = r_opnd;
        w_sh_amt = r_amt;
        if (r_state == PASS2) begin
            w_sh_in  = bitreverse16(r_opnd);
            w_sh_amt = AMT_W'(5'd16 - {1'b0, r_amt});
        end
    end
`else
    assign w_sh_in  = r_opnd;
    assign w_sh_amt = r_amt;
`endif

    shift_sched_barrel u_barrel (
        .i_data (w_sh_in),
        .i_s0   (w_sh_amt[0]),
        .i_s1   (w_sh_amt[1]),
        .i_s2   (w_sh_amt[2]),
        .i_s3   (w_sh_amt[3]),
        .o_data (w_sh_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = PASS1;
                end
            end
            PASS1: begin
`ifdef SHIFT_SCHED_ROT_EN
                if (r_rot && (r_amt != '0)) begin
                    w_next = PASS2;
                end else begin
                    w_next = RESP;
                end
`else
                w_next = RESP;
`endif
            end
            PASS2: w_next = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr  <= IDW'(NREQ - 1);
            r_id   <= '0;
            r_opnd <= '0;
            r_amt  <= '0;
            r_acc  <= '0;
`ifdef SHIFT_SCHED_ROT_EN
            r_rot  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opnd <= bus.req_data[DATA_W*w_grant +: DATA_W];
                        r_amt  <= bus.req_amt[AMT_W*w_grant +: AMT_W];
                        r_id   <= w_grant;
                        r_ptr  <= w_grant;
`ifdef SHIFT_SCHED_ROT_EN
                        r_rot  <= bus.req_rot[w_grant];
`endif
                    end
                end
                PASS1: r_acc <= w_sh_out;
`ifdef SHIFT_SCHED_ROT_EN
                PASS2: r_acc <= r_acc | bitreverse16(w_sh_out);
`endif
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rst_n && (r_state == RESP);
    assign bus.rsp_data  = r_acc;
    assign bus.rsp_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sched
//  Description : Self-checking bench for shift_sched. A transaction-level
//                reference model (arbitration order, latency, arithmetic
//                shift/rotate result) predicts every output each cycle.
//  Optional    : SHIFT_SCHED_ROT_EN enables rotate stimulus
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sched;

    localparam int NREQ = 3;
    localparam int IDW  = 2;
`ifdef SHIFT_SCHED_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    shift_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_ptr;
    bit          m_busy;
    int          m_wait;
    logic [15:0] m_data;
    int          m_id;
    bit          m_rst_seen;

    logic [15:0] last_data;
    int          q_ids[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [15:0] d, input int a, input bit r);
        if (r && a != 0) return 16'((d << a) | (d >> (16 - a)));
        return 16'(d << a);
    endfunction

    task automatic step(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] d,
                        input logic [4*NREQ-1:0] a, input logic [NREQ-1:0] r,
                        input logic rr, input logic rst_in);
        logic [NREQ-1:0] exp_rdy;
        int g;
        bit found;
        bit exp_v;
        @(negedge clk);
        rst_n         = rst_in;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_amt   = a;
`ifdef SHIFT_SCHED_ROT_EN
        bus.req_rot   = r;
`endif
        bus.rsp_ready = rr;
        #1;
        exp_rdy = '0;
        found   = 1'b0;
        g       = 0;
        if (rst_in && !m_busy) begin
            for (int i = 1; i <= NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (!found && v[k]) begin
                    found = 1'b1;
                    g     = k;
                end
            end
        end
        if (found) exp_rdy[g] = 1'b1;
        exp_v = rst_in && m_busy && (m_wait == 0);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (exp_v) begin
            check("rsp_data", 32'(bus.rsp_data), 32'(m_data));
            check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        end
        if (m_rst_seen) begin
            check("rst_data", 32'(bus.rsp_data), 32'h0);
            check("rst_id", 32'(bus.rsp_id), 32'h0);
        end
        if (bus.rsp_valid && rr) begin
            q_ids.push_back(int'(bus.rsp_id));
            last_data = bus.rsp_data;
        end
        // Advance the model across the coming rising edge
        m_rst_seen = !rst_in;
        if (!rst_in) begin
            m_busy = 1'b0;
            m_ptr  = NREQ - 1;
        end else if (!m_busy) begin
            if (found) begin
                bit ro;
                int am;
                am     = int'(a[4*g +: 4]);
                ro     = ROT_EN && r[g];
                m_busy = 1'b1;
                m_wait = (ro && am != 0) ? 2 : 1;
                m_ptr  = g;
                m_id   = g;
                m_data = ref_op(d[16*g +: 16], am, ro);
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (rr) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, '0, '0, 1'b1, 1'b1);
    endtask

    task automatic do_op(input int k, input logic [15:0] dd, input logic [3:0] aa,
                         input bit ro, input logic [15:0] exp, input string tag);
        logic [16*NREQ-1:0] dv;
        logic [4*NREQ-1:0]  av;
        logic [NREQ-1:0]    rv;
        dv = '0; av = '0; rv = '0;
        dv[16*k +: 16] = dd;
        av[4*k +: 4]   = aa;
        rv[k]          = ro;
        last_data = 16'hDEAD;
        step(NREQ'(1) << k, dv, av, rv, 1'b1, 1'b1);
        idle(4);
        check(tag, 32'(last_data), 32'(exp));
    endtask

    task automatic rand_step(input logic [NREQ-1:0] vmask, input logic rr, input logic rst_in);
        logic [16*NREQ-1:0] dv;
        logic [4*NREQ-1:0]  av;
        logic [NREQ-1:0]    rv;
        for (int k = 0; k < NREQ; k++) begin
            dv[16*k +: 16] = 16'($urandom);
            av[4*k +: 4]   = 4'($urandom_range(0, 15));
            rv[k]          = ROT_EN ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        step(vmask, dv, av, rv, rr, rst_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_before;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
`ifdef SHIFT_SCHED_ROT_EN
        bus.req_rot   = '0;
`endif
        bus.rsp_ready = 1'b0;
        m_busy     = 1'b0;
        m_ptr      = NREQ - 1;
        m_wait     = 0;
        m_data     = '0;
        m_id       = 0;
        m_rst_seen = 1'b1;
        last_data  = '0;
        repeat (2) @(posedge clk);

        // Reset: outputs quiet even with every request valid
        rand_step('1, 1'b1, 1'b0);

        // Plain shifts, including the edge amounts
        do_op(0, 16'h00FF, 4'd4,  1'b0, 16'h0FF0, "shl_00ff_4");
        check("shl_00ff_4_id", 32'(q_ids[$]), 32'd0);
        do_op(1, 16'hFFFF, 4'd8,  1'b0, 16'hFF00, "shl_ffff_8");
        do_op(1, 16'hFFFF, 4'd15, 1'b0, 16'h8000, "shl_ffff_15");
        do_op(2, 16'hFFFF, 4'd0,  1'b0, 16'hFFFF, "shl_ffff_0");
        check("shl_ffff_0_id", 32'(q_ids[$]), 32'd2);
`ifdef SHIFT_SCHED_ROT_EN
        do_op(0, 16'h8001, 4'd1, 1'b1, 16'h0003, "rol_8001_1");
        do_op(1, 16'h1234, 4'd4, 1'b1, 16'h2341, "rol_1234_4");
        do_op(0, 16'h1234, 4'd0, 1'b1, 16'h1234, "rol_1234_0");
`endif

        // Round robin between requesters 0 and 1, from reset
        rand_step('0, 1'b1, 1'b0);
        q_ids.delete();
        repeat (18) rand_step(3'b011, 1'b1, 1'b1);
        check("rr_count", 32'(q_ids.size()), 32'd6);
        for (int i = 0; i < 6 && i < q_ids.size(); i++) begin
            check("rr_id", 32'(q_ids[i]), 32'(i % 2));
        end

        // Backpressure: result held, no new grant
        do_op(2, 16'h0F0F, 4'd3, 1'b0, 16'h7878, "bp_pre");
        rand_step(3'b001, 1'b1, 1'b1);
        rand_step('0, 1'b1, 1'b1);
        repeat (5) rand_step('1, 1'b0, 1'b1);
        rand_step('0, 1'b1, 1'b1);
        idle(2);

        // Reset during PASS1 drops the operation; requester 0 wins next
        n_before = q_ids.size();
        rand_step(3'b010, 1'b1, 1'b1);
        rand_step('1, 1'b1, 1'b0);
        rand_step('0, 1'b1, 1'b1);
        check("rst_no_rsp", 32'(q_ids.size()), 32'(n_before));
        rand_step('1, 1'b1, 1'b1);
        idle(4);

        // Randomised traffic with backpressure and occasional reset
        repeat (3000) begin
            rand_step(NREQ'($urandom), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 299) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sched.md
# shift_sched

Shared-shifter scheduler. Arbitrates round-robin among NREQ requesters, each offering a 16-bit operand and a 4-bit left-shift amount over a valid/ready handshake. Sequences each granted operation through a single internal 16-bit left barrel shifter, one or two passes per operation. Returns the result with the requester id on a valid/ready response port. Sits between the ALU-side requesters and the shared barrel shifter datapath.

## Interface
- NREQ, 2, number of requesters (2..8)
- IDW, $clog2(NREQ) (min 1), width of rsp_id
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_data  in  16*NREQ  operand, requester k at [16k+15:16k]
- req_amt  in  4*NREQ  shift amount, requester k at [4k+3:4k]
- req_rot  in  NREQ  1 = rotate-left instead of shift-left (present only with SHIFT_SCHED_ROT_EN)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result
- rsp_id  out  IDW  index of requester that issued the operation

## Operation
- FSM states: IDLE, PASS1, PASS2, RESP.
- IDLE: arbiter picks the first valid requester starting at ptr+1 (mod NREQ). req_ready[grant] = 1 combinationally; all others 0. On handshake: latch operand, amt, rot, id; ptr <= grant; go to PASS1. With no valid request, stay in IDLE.
- PASS1: shifter input = latched operand, amount = amt. Result is registered into acc (acc = operand << amt, zero-fill). If rot && amt != 0, go to PASS2; otherwise go to RESP.
- PASS2 (rotate only): shifter input = bitreverse(operand), amount = 16-amt (1..15, 4 bits). acc <= acc | bitreverse(shifter_out), which gives operand rotated left by amt. Go to RESP.
- RESP: rsp_valid = 1; rsp_data = acc, rsp_id = latched id, both stable while rsp_valid && !rsp_ready. On rsp_ready go to IDLE.
- req_ready is 0 in every state except IDLE. A new request is never accepted in the same cycle as a response handshake.
- Shift by 0 returns the operand unchanged. Rotate by 0 skips PASS2 and returns the operand.
- Shift by 15 keeps only bit 0, moved to bit 15. Bits shifted out are lost.
- Round-robin fairness: with all requesters valid, grants go 0,1,...,NREQ-1,0,...
- Requester k may drop req_valid before it is granted; no state is kept for ungranted requests.

## Timing
- Reset values: state IDLE, ptr = NREQ-1 (requester 0 wins first), acc 0, rsp_valid 0, rsp_data 0, rsp_id 0, req_ready 0 while rst_n = 0.
- Accept in cycle T. Plain shift: rsp_valid first high in T+2. Rotate with amt != 0: rsp_valid first high in T+3.
- Minimum issue interval, with rsp_ready held high: 3 cycles for shift, 4 cycles for rotate.
- Reset asserted mid-operation discards the in-flight operation; no response is produced.
- The shifter is combinational within one cycle. Its output is registered only into acc.

## Configuration
- SHIFT_SCHED_ROT_EN defined: req_rot port exists; PASS2 and the bit-reverse logic are built.
- Not defined: req_rot port absent; PASS2 unreachable and not synthesised; every operation is a plain left shift with latency 2.

## Structure
- Shared package shift_pkg holds:
  - state enum type (IDLE/PASS1/PASS2/RESP)
  - constants DATA_W = 16, AMT_W = 4
  - bitreverse16 function
- One sub-module: the existing 16-bit left barrel shifter, instantiated once. Shifter select s3..s0 = amount bits 3..0.
- Arbiter and FSM stay in shift_sched. No separate arbiter module.

## Test plan
- Single requester 0: data 0x00FF, amt 4, shift -> rsp_data 0x0FF0, rsp_id 0, rsp_valid at T+2.
- Upper-bit check: data 0xFFFF, amt 8 -> 0xFF00; amt 15 -> 0x8000; amt 0 -> 0xFFFF.
- Both requesters held valid for 6 operations, rsp_ready = 1 -> grant/rsp_id sequence 0,1,0,1,0,1; req_ready never high on both.
- Backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp_data/rsp_id held stable; req_ready stays 0 throughout.
- With SHIFT_SCHED_ROT_EN: data 0x8001, amt 1, rot -> 0x0003 at T+3; data 0x1234, amt 4 -> 0x2341; amt 0 -> 0x1234 at T+2.
- rst_n low during PASS1 -> next cycle state IDLE, rsp_valid 0; first grant after reset goes to requester 0.
